// File: rtl/udp_table_pkg.sv
// Shared definitions for the UDP filter table: entry field layout,
// parameter defaults and the searcher FSM state encoding.
package udp_table_pkg;

  // Parameter defaults
  localparam int DEF_TABLE_WIDTH = 64;
  localparam int DEF_DEPTH_BIT   = 9;
  localparam int DEF_RD_LATENCY  = 3;

  // Entry layout: reserved[63:49], valid[48], dst_ip[47:16], dst_port[15:0]
  localparam int VALID_BIT = 48;
  localparam int IP_MSB    = 47;
  localparam int IP_LSB    = 16;
  localparam int PORT_MSB  = 15;
  localparam int PORT_LSB  = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } search_state_t;

endpackage

// File: rtl/udp_tag_delay.sv
// Shift register carrying the (valid, addr) tag of each table read for DEPTH
// cycles, so that the tag emerges together with the read data it describes.
module udp_tag_delay #(
  parameter int DEPTH = 3,
  parameter int AW    = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [AW-1:0] in_addr,
  output logic          out_valid,
  output logic [AW-1:0] out_addr
);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic          v_d;
      logic [AW-1:0] a_d;
      logic          v_q;
      logic [AW-1:0] a_q;

      if (gi == 0) begin : g_first
        assign v_d = in_valid;
        assign a_d = in_addr;
      end else begin : g_rest
        assign v_d = g_stage[gi-1].v_q;
        assign a_d = g_stage[gi-1].a_q;
      end

      // One pipeline stage; flush drops in-flight tags so stale reads never match.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v_q <= 1'b0;
          a_q <= '0;
        end else begin
          v_q <= flush ? 1'b0 : v_d;
          a_q <= a_d;
        end
      end
    end
  endgenerate

  assign out_valid = g_stage[DEPTH-1].v_q;
  assign out_addr  = g_stage[DEPTH-1].a_q;

endmodule

// File: rtl/udp_table_searcher.sv
// Linear scan of the active UDP filter table for a destination IP/port.
// Issues one read per cycle, compares returns as they arrive and stops on
// the first match, so the lowest matching index always wins.
module udp_table_searcher
  import udp_table_pkg::*;
#(
  parameter int UDP_TABLE_WIDTH     = DEF_TABLE_WIDTH,
  parameter int UDP_TABLE_DEPTH_BIT = DEF_DEPTH_BIT,
  parameter int RD_LATENCY          = DEF_RD_LATENCY
) (
  input  logic                           clk_rd,
  input  logic                           rst_rd_n,
  input  logic                           search_req,
  input  logic [31:0]                    search_ip,
  input  logic [15:0]                    search_port,
  input  logic [UDP_TABLE_DEPTH_BIT:0]   entry_num,
  output logic                           search_busy,
  output logic                           search_done,
  output logic                           search_hit,
  output logic [UDP_TABLE_DEPTH_BIT-1:0] search_index,
  output logic                           search_drop,
  output logic [UDP_TABLE_DEPTH_BIT-1:0] tbl_rd_addr,
  input  logic [UDP_TABLE_WIDTH-1:0]     tbl_rd_data
);

  localparam int AW = UDP_TABLE_DEPTH_BIT;
  localparam int CW = UDP_TABLE_DEPTH_BIT + 1;
  localparam logic [CW-1:0] MAX_COUNT = {1'b1, {AW{1'b0}}};

  search_state_t state, state_next;

  logic [31:0]   key_ip;
  logic [15:0]   key_port;
  logic [CW-1:0] count;
  logic [CW-1:0] issue_cnt;
  logic [CW-1:0] clamped_num;
  logic          hit_q;
  logic [AW-1:0] index_q;

  logic          accept;
  logic          in_scan;
  logic          tag_valid;
  logic [AW-1:0] tag_addr;
  logic          entry_match;
  logic          last_tag;
  logic          unused_reserved;

  assign clamped_num = (entry_num > MAX_COUNT) ? MAX_COUNT : entry_num;
  assign accept      = (state == ST_IDLE) && search_req;
  assign in_scan     = (state == ST_SCAN) || (state == ST_DRAIN);

  // Tags travel alongside the reads; cleared whenever no scan is running.
  udp_tag_delay #(
    .DEPTH (RD_LATENCY),
    .AW    (AW)
  ) u_tag_delay (
    .clk       (clk_rd),
    .rst_n     (rst_rd_n),
    .flush     (!in_scan),
    .in_valid  (state == ST_SCAN),
    .in_addr   (issue_cnt[AW-1:0]),
    .out_valid (tag_valid),
    .out_addr  (tag_addr)
  );

  assign entry_match = in_scan && tag_valid && tbl_rd_data[VALID_BIT]
                    && (tbl_rd_data[IP_MSB:IP_LSB] == key_ip)
                    && (tbl_rd_data[PORT_MSB:PORT_LSB] == key_port);
  assign last_tag    = tag_valid && ({1'b0, tag_addr} == count - CW'(1));
  assign unused_reserved = ^tbl_rd_data[UDP_TABLE_WIDTH-1:VALID_BIT+1];

  // State register.
  always_ff @(posedge clk_rd or negedge rst_rd_n) begin
    if (!rst_rd_n) state <= ST_IDLE;
    else           state <= state_next;
  end

  // Next-state logic: a match aborts the scan, a miss waits for the last return.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (search_req) state_next = (clamped_num == '0) ? ST_DONE : ST_SCAN;
      ST_SCAN: begin
        if (entry_match)                        state_next = ST_DONE;
        else if (issue_cnt == count - CW'(1))   state_next = ST_DRAIN;
      end
      ST_DRAIN: if (entry_match || last_tag)    state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Key capture, read address counter and result registers.
  always_ff @(posedge clk_rd or negedge rst_rd_n) begin
    if (!rst_rd_n) begin
      key_ip    <= '0;
      key_port  <= '0;
      count     <= '0;
      issue_cnt <= '0;
      hit_q     <= 1'b0;
      index_q   <= '0;
    end else begin
      if (accept) begin
        key_ip    <= search_ip;
        key_port  <= search_port;
        count     <= clamped_num;
        issue_cnt <= '0;
        hit_q     <= 1'b0;
        index_q   <= '0;
      end else if (state == ST_SCAN) begin
        issue_cnt <= issue_cnt + CW'(1);
      end
      if (entry_match) begin
        hit_q   <= 1'b1;
        index_q <= tag_addr;
      end
    end
  end

  assign search_busy  = in_scan;
  assign search_done  = (state == ST_DONE);
  assign search_hit   = hit_q;
  assign search_index = index_q;
  assign search_drop  = search_req && (state != ST_IDLE);
  assign tbl_rd_addr  = (state == ST_SCAN) ? issue_cnt[AW-1:0] : '0;

endmodule

// File: tb/tb_udp_table_searcher.sv
// Directed bench for udp_table_searcher: models the 3-cycle table read port,
// runs hand-computed search scenarios and checks cycle-exact behaviour.
module tb_udp_table_searcher;

  logic        clk_rd = 1'b0;
  logic        rst_rd_n = 1'b0;
  logic        search_req = 1'b0;
  logic [31:0] search_ip = '0;
  logic [15:0] search_port = '0;
  logic [9:0]  entry_num = '0;
  logic        search_busy, search_done, search_hit, search_drop;
  logic [8:0]  search_index, tbl_rd_addr;
  logic [63:0] tbl_rd_data;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [31:0] KEY_IP   = 32'h0A00_0005;  // 10.0.0.5
  localparam logic [15:0] KEY_PORT = 16'd1234;

  always #5 clk_rd = ~clk_rd;

  udp_table_searcher dut (
    .clk_rd       (clk_rd),
    .rst_rd_n     (rst_rd_n),
    .search_req   (search_req),
    .search_ip    (search_ip),
    .search_port  (search_port),
    .entry_num    (entry_num),
    .search_busy  (search_busy),
    .search_done  (search_done),
    .search_hit   (search_hit),
    .search_index (search_index),
    .search_drop  (search_drop),
    .tbl_rd_addr  (tbl_rd_addr),
    .tbl_rd_data  (tbl_rd_data)
  );

  // Table model: address register, RAM, output register.
  logic [63:0] mem [512];
  logic [8:0]  ram_a = '0;
  logic [63:0] ram_d = '0;
  logic [63:0] rd_q  = '0;
  always @(posedge clk_rd) begin
    ram_a <= tbl_rd_addr;
    ram_d <= mem[ram_a];
    rd_q  <= ram_d;
  end
  assign tbl_rd_data = rd_q;

  function automatic logic [63:0] mk_entry(input logic [31:0] ip, input logic [15:0] port,
                                           input logic v);
    return {15'h7fff, v, ip, port};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 512; i++) mem[i] = 64'h0;
  endtask

  // One request; checks per-cycle address/busy/done/drop and the result.
  task automatic run_search(input string name, input logic [9:0] n, input int exp_done,
                            input logic exp_hit, input int exp_idx, input int drop_cyc);
    int n_eff, addr_err, busy_err, done_err, drop_err, seen_done, exp_addr;
    logic hit_at_done;
    logic [8:0] idx_at_done;
    n_eff = (n > 10'd512) ? 512 : int'(n);
    addr_err = 0; busy_err = 0; done_err = 0; drop_err = 0; seen_done = 0;
    hit_at_done = 1'b0; idx_at_done = '0;
    @(negedge clk_rd);
    search_req  = 1'b1;
    search_ip   = KEY_IP;
    search_port = KEY_PORT;
    entry_num   = n;
    @(posedge clk_rd);
    #1;
    for (int cyc = 1; cyc <= exp_done + 1; cyc++) begin
      search_req = (cyc == drop_cyc);
      search_ip  = 32'hDEAD_BEEF;
      #1;
      exp_addr = (cyc <= n_eff && cyc < exp_done) ? cyc - 1 : 0;
      if (tbl_rd_addr !== 9'(exp_addr)) addr_err++;
      if (search_busy !== (cyc < exp_done)) busy_err++;
      if (search_done !== (cyc == exp_done)) done_err++;
      if (search_drop !== (cyc == drop_cyc)) drop_err++;
      if (search_done && seen_done == 0) begin
        seen_done   = cyc;
        hit_at_done = search_hit;
        idx_at_done = search_index;
      end
      if (cyc <= exp_done) begin
        @(posedge clk_rd);
        #1;
      end
    end
    search_req = 1'b0;
    check({name, " done_cycle"}, seen_done, exp_done);
    check({name, " hit"}, hit_at_done, exp_hit);
    check({name, " index"}, idx_at_done, exp_idx);
    check({name, " hit_held"}, search_hit, exp_hit);
    check({name, " index_held"}, search_index, exp_idx);
    check({name, " addr_trace_errs"}, addr_err, 0);
    check({name, " busy_errs"}, busy_err, 0);
    check({name, " done_errs"}, done_err, 0);
    check({name, " drop_errs"}, drop_err, 0);
    $display("search %s: n=%0d done@T0+%0d hit=%0b index=%0d", name, n, seen_done,
             hit_at_done, idx_at_done);
  endtask

  initial begin
    int rst_done_err;
    clear_mem();

    // Reset state
    #12;
    check("rst busy", search_busy, 0);
    check("rst done", search_done, 0);
    check("rst hit", search_hit, 0);
    check("rst drop", search_drop, 0);
    check("rst index", search_index, 0);
    check("rst addr", tbl_rd_addr, 0);
    @(negedge clk_rd);
    rst_rd_n = 1'b1;

    // Hit at index 0: done at T0+5
    mem[0] = mk_entry(KEY_IP, KEY_PORT, 1'b1);
    run_search("hit0", 10'd4, 5, 1'b1, 0, 0);

    // Lowest of two matches wins: index 7, done at T0+12
    clear_mem();
    mem[7]  = mk_entry(KEY_IP, KEY_PORT, 1'b1);
    mem[20] = mk_entry(KEY_IP, KEY_PORT, 1'b1);
    run_search("hit7", 10'd32, 12, 1'b1, 7, 0);

    // Full miss over 512 entries with near misses: done at T0+516
    clear_mem();
    mem[3] = mk_entry(KEY_IP, 16'd1235, 1'b1);
    mem[5] = mk_entry(32'h0A00_0006, KEY_PORT, 1'b1);
    run_search("miss512", 10'd512, 516, 1'b0, 0, 0);

    // Matching key but valid=0: miss, done at T0+8+3+1
    clear_mem();
    mem[2] = mk_entry(KEY_IP, KEY_PORT, 1'b0);
    run_search("invalid", 10'd8, 12, 1'b0, 0, 0);

    // Zero entries: immediate miss at T0+1
    run_search("zero", 10'd0, 1, 1'b0, 0, 0);

    // 600 entries clamped to 512
    clear_mem();
    run_search("clamp600", 10'd600, 516, 1'b0, 0, 0);

    // Requests while scanning and while done are dropped
    mem[7]  = mk_entry(KEY_IP, KEY_PORT, 1'b1);
    mem[20] = mk_entry(KEY_IP, KEY_PORT, 1'b1);
    mem[0]  = mk_entry(32'hDEAD_BEEF, KEY_PORT, 1'b1);
    run_search("drop_scan", 10'd32, 12, 1'b1, 7, 3);
    run_search("drop_done", 10'd32, 12, 1'b1, 7, 12);

    // Asynchronous reset in the middle of a scan
    @(negedge clk_rd);
    search_req  = 1'b1;
    search_ip   = KEY_IP;
    search_port = KEY_PORT;
    entry_num   = 10'd32;
    @(posedge clk_rd);
    #1;
    search_req = 1'b0;
    repeat (5) @(posedge clk_rd);
    #3;
    rst_rd_n = 1'b0;
    #1;
    check("midrst busy", search_busy, 0);
    check("midrst done", search_done, 0);
    check("midrst hit", search_hit, 0);
    check("midrst index", search_index, 0);
    check("midrst addr", tbl_rd_addr, 0);
    rst_done_err = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_rd);
      if (i == 3) rst_rd_n = 1'b1;
      if (search_done !== 1'b0 || search_busy !== 1'b0) rst_done_err++;
    end
    check("midrst no_done", rst_done_err, 0);
    $display("reset mid-scan: outputs cleared, no completion seen");

    // Fresh request after reset behaves normally
    run_search("after_rst", 10'd32, 12, 1'b1, 7, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
